// File: rtl/sn2bin_dec_pkg.sv
// Purpose: shared stochastic-decode types, FSM encoding and default constants.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package sn2bin_dec_pkg;

  // Default datapath geometry
  localparam int NLANE_DEF = 16;
  localparam int OUT_W_DEF = 8;

  // Longest window in beats; a win_len code of 0 selects it
  localparam int WIN_MAX = 16;

  // Beat counter must represent 0..WIN_MAX
  localparam int CNT_W = $clog2(WIN_MAX + 1);

  // Converter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } sn_state_t;

  // Map the 4-bit window code to a beat count (0 means the full 16 beats)
  function automatic logic [CNT_W-1:0] win_beats(input logic [3:0] code);
    logic [CNT_W-1:0] beats;
    if (code == 4'd0) begin
      beats = CNT_W'(WIN_MAX);
    end else begin
      beats = CNT_W'(code);
    end
    return beats;
  endfunction

endpackage

// File: rtl/sn2bin_dec_popcount.sv
// Purpose: count the set lanes of one stochastic beat.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the input every cycle.
module popcount_16b #(
  parameter int NLANE = sn2bin_dec_pkg::NLANE_DEF,
  parameter int CNT_W = $clog2(NLANE + 1)
) (
  input  logic [NLANE-1:0] bits,
  output logic [CNT_W-1:0] cnt
);

  // Sum every lane; the tool is free to build this as an adder tree
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NLANE; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sn2bin_dec.sv
// Purpose: decode a window of stochastic beats into a saturated binary count.
// Latency: result valid exactly one cycle after the last accepted beat.
// Backpressure: result holds in HOLD until out_rdy; sn_vld low stalls the window.
module sn2bin_dec
  import sn2bin_dec_pkg::*;
#(
  parameter int NLANE = NLANE_DEF,
  parameter int OUT_W = OUT_W_DEF,
  // Must satisfy ACC_W >= OUT_W and 2^ACC_W > NLANE*WIN_MAX
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       win_len,
  input  logic [NLANE-1:0] sn_in,
  input  logic             sn_vld,
  input  logic             clr,
  output logic [OUT_W-1:0] bin_out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             sat,
  output logic             busy
);

  localparam int PC_W = $clog2(NLANE + 1);

  // Largest value representable on bin_out, expressed at accumulator width
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  sn_state_t        state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [PC_W-1:0]  pc;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_nxt;
  logic [OUT_W-1:0] bin_nxt;

  popcount_16b #(
    .NLANE (NLANE),
    .CNT_W (PC_W)
  ) u_popcount (
    .bits (sn_in),
    .cnt  (pc)
  );

  // Next accumulator value; pins at all-ones rather than wrapping, and the
  // output clip to OUT_W is decided from the unclipped sum
  always_comb begin
    acc_sum = {1'b0, acc} + (ACC_W + 1)'(pc);
    if (acc_sum[ACC_W]) begin
      acc_nxt = '1;
    end else begin
      acc_nxt = acc_sum[ACC_W-1:0];
    end
    sat_nxt = (acc_nxt > OUT_MAX);
    if (sat_nxt) begin
      bin_nxt = '1;
    end else begin
      bin_nxt = acc_nxt[OUT_W-1:0];
    end
  end

  // Converter FSM with registered outputs; clr outranks every other input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
      out_vld <= 1'b0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else if (clr) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
      out_vld <= 1'b0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= win_beats(win_len);
            state <= ST_ACC;
            busy  <= 1'b1;
          end
        end

        ST_ACC: begin
          // start is deliberately ignored here; sn_vld low simply stalls
          if (sn_vld) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state   <= ST_HOLD;
              out_vld <= 1'b1;
              bin_out <= bin_nxt;
              sat     <= sat_nxt;
            end
          end
        end

        ST_HOLD: begin
          // Result is frozen until the consumer takes it
          if (out_rdy) begin
            out_vld <= 1'b0;
            bin_out <= '0;
            sat     <= 1'b0;
            if (start) begin
              // Back-to-back window: skip IDLE entirely
              acc   <= '0;
              cnt   <= win_beats(win_len);
              state <= ST_ACC;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          acc     <= '0;
          cnt     <= '0;
          bin_out <= '0;
          out_vld <= 1'b0;
          sat     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn2bin_dec.sv
// Purpose: directed self-checking bench for sn2bin_dec with a result scoreboard.
// Latency: checks out_vld one cycle after the last accepted beat.
// Backpressure: exercises HOLD stalls, back-to-back windows and aborts.
module tb_sn2bin_dec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  win_len;
  logic [15:0] sn_in;
  logic        sn_vld;
  logic        clr;
  logic [7:0]  bin_out;
  logic        out_vld;
  logic        out_rdy;
  logic        sat;
  logic        busy;

  typedef struct packed {
    logic [7:0] bin;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   msum;
  int   checks   = 0;
  int   failures = 0;

  sn2bin_dec dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .win_len (win_len),
    .sn_in   (sn_in),
    .sn_vld  (sn_vld),
    .clr     (clr),
    .bin_out (bin_out),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .sat     (sat),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] w);
    start   = 1'b1;
    win_len = w;
    msum    = 0;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    sn_in  = d;
    sn_vld = 1'b1;
    msum   = msum + $countones(d);
    @(negedge clk);
    sn_vld = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic push_exp();
    exp_t e;
    e.sat = (msum > 255);
    e.bin = (msum > 255) ? 8'hFF : 8'(msum);
    sb.push_back(e);
  endtask

  // Compare the current output against the oldest expected result
  task automatic check_result(input string tag, output exp_t e);
    chk({tag, "_vld"}, 32'(out_vld), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      e = '0;
    end else begin
      e = sb.pop_front();
      chk({tag, "_bin"}, 32'(bin_out), 32'(e.bin));
      chk({tag, "_sat"}, 32'(sat), 32'(e.sat));
    end
  endtask

  task automatic release_result(input string tag);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk({tag, "_drop"}, 32'(out_vld), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; win_len = 4'd0; sn_in = '0;
    sn_vld = 1'b0; clr = 1'b0; out_rdy = 1'b0; msum = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 16 beats of two set lanes -> 0x20, latency exactly one cycle
    do_start(4'd0);
    chk("w1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 15; i++) beat(16'h0005);
    chk("w1_early", 32'(out_vld), 32'd0);
    beat(16'h0005);
    push_exp();
    check_result("w1", e);
    release_result("w1");

    // All lanes set for 16 beats -> clipped
    do_start(4'd0);
    for (int i = 0; i < 16; i++) beat(16'hFFFF);
    push_exp();
    check_result("w2", e);
    release_result("w2");

    // Stalled 4-beat window: three bubbles after beat 2
    do_start(4'd4);
    beat(16'h00FF);
    beat(16'h00FF);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("w3_stall", 32'(out_vld), 32'd0);
    end
    beat(16'h00FF);
    chk("w3_early", 32'(out_vld), 32'd0);
    beat(16'h00FF);
    push_exp();
    check_result("w3", e);

    // Consumer stalls 5 cycles; result must not move
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      chk("bp_vld", 32'(out_vld), 32'd1);
      chk("bp_bin", 32'(bin_out), 32'(e.bin));
    end
    release_result("w3");

    // start pulsed mid-window with a different length must be ignored
    do_start(4'd8);
    for (int i = 0; i < 3; i++) beat(16'h000F);
    start = 1'b1; win_len = 4'd2;
    sn_in = 16'h000F; sn_vld = 1'b1; msum = msum + 4;
    @(negedge clk);
    start = 1'b0; sn_vld = 1'b0;
    for (int i = 0; i < 3; i++) beat(16'h000F);
    chk("w4_early", 32'(out_vld), 32'd0);
    beat(16'h000F);
    push_exp();
    check_result("w4", e);

    // Back-to-back: accept and restart in the same cycle
    start = 1'b1; win_len = 4'd2; out_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0; out_rdy = 1'b0; msum = 0;
    chk("b2b_vld", 32'(out_vld), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    beat(16'h0003);
    beat(16'h0003);
    push_exp();
    check_result("w5", e);
    release_result("w5");

    // Asynchronous reset mid-window
    do_start(4'd0);
    for (int i = 0; i < 7; i++) beat(16'h0005);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", 32'(out_vld), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bin", 32'(bin_out), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      beat(16'h0005);
      chk("arst_none", 32'(out_vld), 32'd0);
    end

    // Synchronous clear mid-window, asserted alongside a beat
    do_start(4'd0);
    for (int i = 0; i < 7; i++) beat(16'h0005);
    clr = 1'b1; sn_in = 16'hFFFF; sn_vld = 1'b1;
    #1;
    chk("clr_pre", 32'(busy), 32'd1);
    @(negedge clk);
    clr = 1'b0; sn_vld = 1'b0;
    chk("clr_vld", 32'(out_vld), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_sat", 32'(sat), 32'd0);
    for (int i = 0; i < 9; i++) begin
      beat(16'h0005);
      chk("clr_none", 32'(out_vld), 32'd0);
    end

    // Fresh window after abort -> 0x10
    do_start(4'd0);
    for (int i = 0; i < 16; i++) beat(16'h0001);
    push_exp();
    check_result("w6", e);
    release_result("w6");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn2bin_dec.md
SN2BIN_DEC -- requirements
Module: sn2bin_dec

Interface
REQ-001 Parameter NLANE, default 16, number of parallel stochastic bit lanes per beat.
REQ-002 Parameter OUT_W, default 8, width of the binary result.
REQ-003 Parameter ACC_W, default 9, accumulator width; SHALL hold NLANE*16 without overflow.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a conversion window.
REQ-007 win_len  input  4  window length in beats, sampled on accepted start; 0 encodes 16.
REQ-008 sn_in  input  NLANE  stochastic bit lanes of one beat.
REQ-009 sn_vld  input  1  sn_in carries a valid beat this cycle.
REQ-010 clr  input  1  synchronous abort; returns the block to IDLE.
REQ-011 bin_out  output  OUT_W  decoded binary value, valid while out_vld=1.
REQ-012 out_vld  output  1  result available.
REQ-013 out_rdy  input  1  consumer accepts the result.
REQ-014 sat  output  1  result was clipped to 2^OUT_W-1; qualified by out_vld.
REQ-015 busy  output  1  high in ACC and HOLD.

Function
REQ-016 FSM states SHALL be IDLE, ACC and HOLD.
REQ-017 IDLE + start: clear accumulator, load beat counter with win_len (0 -> 16), go to ACC next cycle.
REQ-018 ACC, per cycle with sn_vld=1: accumulator += popcount(sn_in); beat counter decrements by 1.
REQ-019 ACC with sn_vld=0: accumulator and counter hold (stall); no timeout.
REQ-020 Last accepted beat (counter = 1 with sn_vld=1): next cycle state = HOLD, out_vld=1, bin_out = min(final sum, 2^OUT_W-1), sat = (final sum > 2^OUT_W-1).
REQ-021 Latency: out_vld SHALL rise exactly one cycle after the last accepted beat.
REQ-022 HOLD: bin_out, sat and out_vld SHALL stay stable until out_rdy=1.
REQ-023 HOLD + out_rdy=1 + start=0: out_vld low next cycle, go to IDLE.
REQ-024 HOLD + out_rdy=1 + start=1: go directly to ACC with a fresh window (back-to-back). No idle cycle is inserted.
REQ-025 start in ACC, or in HOLD without out_rdy, SHALL be ignored.
REQ-026 sn_vld outside ACC SHALL be ignored.
REQ-027 clr SHALL take priority over all other inputs in every state: next cycle IDLE, accumulator 0, out_vld 0, sat 0.
REQ-028 Popcount SHALL be computed combinationally over all NLANE lanes within one cycle.
REQ-029 Accumulation SHALL be unsigned and non-wrapping within ACC_W. Saturation applies only at the output.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, accumulator 0, beat counter 0, bin_out 0, out_vld 0, sat 0, busy 0.
REQ-031 Reset asserted mid-window SHALL discard the partial window. No result is produced for it.

Structure
REQ-032 The shared stochastic package SHALL hold the FSM state encoding and the constants NLANE_DEF=16, OUT_W_DEF=8 and WIN_MAX=16.
REQ-033 The popcount SHALL be a separate sub-module, popcount_16b (parameterised by NLANE). The FSM, counter and accumulator stay in sn2bin_dec.

Verification
REQ-034 Beats: sn_in=16'h0005 for 16 consecutive beats, win_len=0 -> out_vld 1 cycle after the 16th beat; bin_out=8'h20, sat=0.
REQ-035 Beats: sn_in=16'hFFFF for 16 beats, win_len=0 -> bin_out=8'hFF, sat=1.
REQ-036 Beats: win_len=4, sn_in=16'h00FF, with sn_vld low for 3 cycles after beat 2 -> bin_out=8'h20; out_vld rises 3 cycles later than the unstalled case.
REQ-037 Backpressure and start handling:
- out_rdy held low 5 cycles in HOLD -> bin_out and out_vld stable throughout.
- start pulsed during ACC -> ignored.
- start and out_rdy high together in HOLD -> ACC on the next cycle, new result correct.
REQ-038 Abort mid-window:
- rst pulsed low after beat 7 of 16 -> all outputs 0 asynchronously, no out_vld afterwards.
- clr after beat 7 of 16 -> same outcome, taking effect on the next edge.
- A following start with sn_in=16'h0001 for 16 beats -> bin_out=8'h10.
